// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : RISC-V architectural register file: two combinational read
//               ports, one write port, hardwired-zero x0, sticky ALU flags.
//               Optional macro REGFILE_BYPASS_EN adds same-cycle write-through.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  flag_capture,
    input  logic                  flag_clear,
    input  logic                  alu_carry,
    input  logic                  alu_overflow,
    input  logic                  alu_zero,
    output logic                  sticky_carry,
    output logic                  sticky_overflow,
    output logic                  last_zero
);

    localparam int C_NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [C_NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [C_NUM_REGS];
    logic                  sticky_carry_q, sticky_carry_d;
    logic                  sticky_overflow_q, sticky_overflow_d;
    logic                  last_zero_q, last_zero_d;
    logic                  wr_en;

    assign wr_en = reg_write && (rd_addr != '0);

    always_comb begin
        for (int i = 0; i < C_NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en) begin
            regs_d[rd_addr] = rd_data;
        end
        if (rst) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                regs_d[i] = '0;
            end
        end
    end

    // Clear is applied before capture so a combined request starts from zero.
    always_comb begin
        sticky_carry_d    = sticky_carry_q;
        sticky_overflow_d = sticky_overflow_q;
        last_zero_d       = last_zero_q;
        if (flag_clear) begin
            sticky_carry_d    = 1'b0;
            sticky_overflow_d = 1'b0;
            last_zero_d       = 1'b0;
        end
        if (flag_capture) begin
            sticky_carry_d    = sticky_carry_d | alu_carry;
            sticky_overflow_d = sticky_overflow_d | alu_overflow;
            last_zero_d       = alu_zero;
        end
        if (rst) begin
            sticky_carry_d    = 1'b0;
            sticky_overflow_d = 1'b0;
            last_zero_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < C_NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
        end
        sticky_carry_q    <= sticky_carry_d;
        sticky_overflow_q <= sticky_overflow_d;
        last_zero_q       <= last_zero_d;
    end

    always_comb begin
        rs1_data = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
        rs2_data = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        // Write-through is suppressed during reset so reads see stored state.
        if (!rst && wr_en && (rd_addr == rs1_addr)) begin
            rs1_data = rd_data;
        end
        if (!rst && wr_en && (rd_addr == rs2_addr)) begin
            rs2_data = rd_data;
        end
`endif
    end

    assign sticky_carry    = sticky_carry_q;
    assign sticky_overflow = sticky_overflow_q;
    assign last_zero       = last_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file
// Description : Directed self-checking bench for reg_file; expectations
//               follow REGFILE_BYPASS_EN when that macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] rs1_data, rs2_data, rd_data;
    logic        reg_write, flag_capture, flag_clear;
    logic        alu_carry, alu_overflow, alu_zero;
    logic        sticky_carry, sticky_overflow, last_zero;

    int checks = 0;
    int errors = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    always #5 clk = ~clk;

    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .reg_write       (reg_write),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .flag_capture    (flag_capture),
        .flag_clear      (flag_clear),
        .alu_carry       (alu_carry),
        .alu_overflow    (alu_overflow),
        .alu_zero        (alu_zero),
        .sticky_carry    (sticky_carry),
        .sticky_overflow (sticky_overflow),
        .last_zero       (last_zero)
    );

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        reg_write = 1'b1;
        rd_addr   = a;
        rd_data   = d;
        tick();
        reg_write = 1'b0;
    endtask

    task automatic test_reset();
        do_write(5'd5, 32'hDEADBEEF);
        rs1_addr = 5'd5;
        #1;
        checks++;
        if (rs1_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL preload_x5 got %h exp %h", rs1_data, 32'hDEADBEEF);
        end
        flag_capture = 1'b1; alu_carry = 1'b1; alu_overflow = 1'b1; alu_zero = 1'b1;
        tick();
        flag_capture = 1'b0;
        checks++;
        if ({sticky_carry, sticky_overflow, last_zero} !== 3'b111) begin
            errors++; $display("FAIL preload_flags got %b exp 111", {sticky_carry, sticky_overflow, last_zero});
        end
        rst = 1'b1; reg_write = 1'b1; rd_addr = 5'd7; rd_data = 32'hFFFFFFFF;
        flag_capture = 1'b1; rs2_addr = 5'd7;
        #2;
        checks++;
        if (rs2_data !== 32'h0) begin
            errors++; $display("FAIL reset_bypass_suppressed got %h exp %h", rs2_data, 32'h0);
        end
        tick();
        rst = 1'b0; reg_write = 1'b0; flag_capture = 1'b0;
        alu_carry = 1'b0; alu_overflow = 1'b0; alu_zero = 1'b0;
        #1;
        checks++;
        if (rs1_data !== 32'h0) begin
            errors++; $display("FAIL reset_x5 got %h exp %h", rs1_data, 32'h0);
        end
        checks++;
        if (rs2_data !== 32'h0) begin
            errors++; $display("FAIL reset_x7 got %h exp %h", rs2_data, 32'h0);
        end
        checks++;
        if ({sticky_carry, sticky_overflow, last_zero} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b exp 000", {sticky_carry, sticky_overflow, last_zero});
        end
    endtask

    task automatic test_x0();
        reg_write = 1'b1; rd_addr = 5'd0; rd_data = 32'h12345678; rs1_addr = 5'd0;
        #2;
        checks++;
        if (rs1_data !== 32'h0) begin
            errors++; $display("FAIL x0_pre_edge got %h exp %h", rs1_data, 32'h0);
        end
        tick();
        reg_write = 1'b0;
        #1;
        checks++;
        if (rs1_data !== 32'h0) begin
            errors++; $display("FAIL x0_post_edge got %h exp %h", rs1_data, 32'h0);
        end
    endtask

    task automatic test_write_read();
        do_write(5'd31, 32'hA5A5A5A5);
        do_write(5'd1, 32'h00000001);
        rs1_addr = 5'd31; rs2_addr = 5'd1;
        #1;
        checks++;
        if (rs1_data !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL read_x31 got %h exp %h", rs1_data, 32'hA5A5A5A5);
        end
        checks++;
        if (rs2_data !== 32'h00000001) begin
            errors++; $display("FAIL read_x1 got %h exp %h", rs2_data, 32'h00000001);
        end
        rs2_addr = 5'd31;
        #1;
        checks++;
        if (rs1_data !== 32'hA5A5A5A5 || rs2_data !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL dual_read_x31 got %h/%h exp %h", rs1_data, rs2_data, 32'hA5A5A5A5);
        end
        // Write enable low must leave the target untouched.
        reg_write = 1'b0; rd_addr = 5'd6; rd_data = 32'hCAFEF00D; rs1_addr = 5'd6;
        tick();
        checks++;
        if (rs1_data !== 32'h0) begin
            errors++; $display("FAIL no_write_x6 got %h exp %h", rs1_data, 32'h0);
        end
    endtask

    task automatic test_hazard();
        logic [31:0] exp_pre;
        do_write(5'd3, 32'h10);
        exp_pre = BYPASS ? 32'h20 : 32'h10;
        reg_write = 1'b1; rd_addr = 5'd3; rd_data = 32'h20; rs1_addr = 5'd3; rs2_addr = 5'd3;
        #2;
        checks++;
        if (rs1_data !== exp_pre || rs2_data !== exp_pre) begin
            errors++; $display("FAIL hazard_pre_edge got %h/%h exp %h", rs1_data, rs2_data, exp_pre);
        end
        tick();
        reg_write = 1'b0;
        checks++;
        if (rs1_data !== 32'h20) begin
            errors++; $display("FAIL hazard_post_edge got %h exp %h", rs1_data, 32'h20);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pre;
        reg_write = 1'b1; rd_addr = 5'd4; rd_data = 32'h11; rs1_addr = 5'd4;
        tick();
        rd_data = 32'h22;
        exp_pre = BYPASS ? 32'h22 : 32'h11;
        #1;
        checks++;
        if (rs1_data !== exp_pre) begin
            errors++; $display("FAIL b2b_cycle2 got %h exp %h", rs1_data, exp_pre);
        end
        tick();
        reg_write = 1'b0;
        checks++;
        if (rs1_data !== 32'h22) begin
            errors++; $display("FAIL b2b_final got %h exp %h", rs1_data, 32'h22);
        end
    endtask

    task automatic test_flags();
        flag_clear = 1'b1;
        tick();
        flag_clear = 1'b0;
        flag_capture = 1'b1; alu_overflow = 1'b1; alu_carry = 1'b0; alu_zero = 1'b0;
        tick();
        checks++;
        if ({sticky_carry, sticky_overflow, last_zero} !== 3'b010) begin
            errors++; $display("FAIL flags_cap1 got %b exp 010", {sticky_carry, sticky_overflow, last_zero});
        end
        alu_overflow = 1'b0; alu_zero = 1'b1;
        tick();
        checks++;
        if ({sticky_carry, sticky_overflow, last_zero} !== 3'b011) begin
            errors++; $display("FAIL flags_cap2 got %b exp 011", {sticky_carry, sticky_overflow, last_zero});
        end
        flag_capture = 1'b0; alu_carry = 1'b1; alu_zero = 1'b0;
        tick();
        checks++;
        if ({sticky_carry, sticky_overflow, last_zero} !== 3'b011) begin
            errors++; $display("FAIL flags_hold got %b exp 011", {sticky_carry, sticky_overflow, last_zero});
        end
        alu_carry = 1'b0; flag_clear = 1'b1;
        tick();
        checks++;
        if ({sticky_carry, sticky_overflow, last_zero} !== 3'b000) begin
            errors++; $display("FAIL flags_clear got %b exp 000", {sticky_carry, sticky_overflow, last_zero});
        end
        flag_clear = 1'b0; flag_capture = 1'b1; alu_overflow = 1'b1; alu_zero = 1'b1;
        tick();
        flag_clear = 1'b1; alu_carry = 1'b1; alu_overflow = 1'b0; alu_zero = 1'b0;
        tick();
        flag_clear = 1'b0; flag_capture = 1'b0; alu_carry = 1'b0;
        checks++;
        if ({sticky_carry, sticky_overflow, last_zero} !== 3'b100) begin
            errors++; $display("FAIL flags_clear_and_capture got %b exp 100", {sticky_carry, sticky_overflow, last_zero});
        end
    endtask

    task automatic test_alu_hookup();
        logic [32:0] sum;
        logic        ovf;
        flag_clear = 1'b1;
        tick();
        flag_clear = 1'b0;
        do_write(5'd1, 32'h7FFFFFFF);
        do_write(5'd2, 32'h00000001);
        rs1_addr = 5'd1; rs2_addr = 5'd2;
        #1;
        checks++;
        if (rs1_data !== 32'h7FFFFFFF || rs2_data !== 32'h00000001) begin
            errors++; $display("FAIL alu_operands got %h/%h exp 7fffffff/00000001", rs1_data, rs2_data);
        end
        // Reference 32-bit adder on the fixed operands.
        sum = {1'b0, 32'h7FFFFFFF} + {1'b0, 32'h00000001};
        ovf = ~(1'b0 ^ 1'b0) & (sum[31] ^ 1'b0);
        flag_capture = 1'b1; alu_carry = sum[32]; alu_overflow = ovf; alu_zero = (sum[31:0] == 32'h0);
        reg_write = 1'b1; rd_addr = 5'd3; rd_data = sum[31:0];
        tick();
        flag_capture = 1'b0; reg_write = 1'b0;
        alu_carry = 1'b0; alu_overflow = 1'b0; alu_zero = 1'b0;
        rs1_addr = 5'd3;
        #1;
        checks++;
        if ({sticky_carry, sticky_overflow, last_zero} !== 3'b010) begin
            errors++; $display("FAIL alu_flags got %b exp 010", {sticky_carry, sticky_overflow, last_zero});
        end
        checks++;
        if (rs1_data !== 32'h80000000) begin
            errors++; $display("FAIL alu_writeback_x3 got %h exp %h", rs1_data, 32'h80000000);
        end
    endtask

    initial begin
        rst = 1'b1; reg_write = 1'b0; rd_addr = '0; rd_data = '0;
        rs1_addr = '0; rs2_addr = '0;
        flag_capture = 1'b0; flag_clear = 1'b0;
        alu_carry = 1'b0; alu_overflow = 1'b0; alu_zero = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_x0();
        test_write_read();
        test_hazard();
        test_back_to_back();
        test_flags();
        test_alu_hookup();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file.md
# reg_file

Architectural register file for the single-cycle RISC-V datapath. It sits directly upstream of the ALU and supplies `rs1_data` to `A_in` and `rs2_data` to `B_in` through the operand mux. It provides:
- two combinational read ports;
- one synchronous write port for write-back;
- hardwired-zero `x0`;
- a sticky ALU status register that accumulates carry/overflow and records the last zero flag for trap/debug logic.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register width; must equal the ALU operand width.
- `ADDR_WIDTH`, 5, register index width; the file holds 2**`ADDR_WIDTH` registers.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `rs1_addr`  input  `ADDR_WIDTH`  read port 1 index.
- `rs2_addr`  input  `ADDR_WIDTH`  read port 2 index.
- `rs1_data`  output  `DATA_WIDTH`  read port 1 data, to ALU `A_in`.
- `rs2_data`  output  `DATA_WIDTH`  read port 2 data, to ALU `B_in` via the immediate mux.
- `reg_write`  input  1  write enable.
- `rd_addr`  input  `ADDR_WIDTH`  write index.
- `rd_data`  input  `DATA_WIDTH`  write-back data from the ALU/memory mux.
- `flag_capture`  input  1  sample ALU flags this cycle; asserted for arithmetic instructions.
- `flag_clear`  input  1  clear sticky flags.
- `alu_carry`  input  1  ALU `carry_out`.
- `alu_overflow`  input  1  ALU `overflow`.
- `alu_zero`  input  1  ALU `zero`.
- `sticky_carry`  output  1  OR of all captured carries since the last clear/reset.
- `sticky_overflow`  output  1  OR of all captured overflows since the last clear/reset.
- `last_zero`  output  1  `alu_zero` at the most recent capture.

## Operation
- Storage: 2**`ADDR_WIDTH` words of `DATA_WIDTH` bits.
- Register 0 is never written and always reads as 0, with or without bypass.
- Reads are purely combinational from `rs*_addr` and register contents; no read enable.
- Write: on the rising edge with `reg_write`=1 and `rd_addr`≠0, `reg[rd_addr]` <= `rd_data`. Writes with `rd_addr`=0 are dropped silently.
- Both read ports may address the same register, including the register being written.
- Flag register, on the rising edge:
  - `flag_clear`=1 and `flag_capture`=0: all three flags <= 0.
  - `flag_capture`=1 and `flag_clear`=0:
    - `sticky_carry` <= `sticky_carry` | `alu_carry`
    - `sticky_overflow` <= `sticky_overflow` | `alu_overflow`
    - `last_zero` <= `alu_zero`
  - Both asserted: clear first, then capture. Result is `sticky_carry`=`alu_carry`, `sticky_overflow`=`alu_overflow`, `last_zero`=`alu_zero`.
  - Neither asserted: hold.
- Reset: on the rising edge with `rst`=1:
  - every register and all three flags <= 0, in one cycle;
  - reset has priority over `reg_write`, `flag_capture` and `flag_clear` in that cycle.
- Outputs after reset: `rs1_data`=0, `rs2_data`=0, `sticky_carry`=0, `sticky_overflow`=0, `last_zero`=0.
- Unknown (X) write data propagates normally; no masking.

## Timing
- Read latency: 0 cycles (combinational).
- Write latency: data is visible on the read ports after the next rising edge, or in the same cycle when bypass is compiled in.
- Flag latency: 1 cycle from `flag_capture` to the outputs.
- A single-cycle instruction reads in cycle N and writes back at the end of cycle N. The following instruction reads the new value in cycle N+1 without stalls.
- `rst` deasserting mid-program: the first post-reset edge behaves as a normal cycle. No warm-up state.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - `rsN_data` = `rd_data` whenever `reg_write`=1, `rd_addr`=`rsN_addr` and `rd_addr`≠0, in the same cycle (write-through);
  - `rst`=1 suppresses the bypass, so reads return stored values (0 after the edge).
- Not defined: reads always return stored contents. A same-cycle write is visible only after the edge.

## Test plan
- Reset: preload x5=0xDEADBEEF, assert `rst` one cycle with `reg_write`=1, `rd_addr`=7 -> x5=0, x7=0, all flags 0 after the edge.
- x0: write 0x12345678 to x0, read `rs1_addr`=0 -> `rs1_data`=0 before and after the edge, both bypass builds.
- Write/read: write 0xA5A5A5A5 to x31 and 0x00000001 to x1 on consecutive cycles; read `rs1`=31, `rs2`=1 -> 0xA5A5A5A5 and 0x00000001. Dual read of the same address x31 -> both ports 0xA5A5A5A5.
- Same-cycle hazard: x3=0x10, write 0x20 to x3 while `rs1_addr`=3 -> pre-edge `rs1_data`=0x20 with `REGFILE_BYPASS_EN`, 0x10 without; 0x20 after the edge in both builds.
- Sticky flags:
  - capture `alu_overflow`=1, then capture `alu_overflow`=0 with `alu_zero`=1 -> `sticky_overflow`=1, `last_zero`=1;
  - `flag_clear` -> all 0;
  - simultaneous clear+capture with `alu_carry`=1 -> `sticky_carry`=1, `sticky_overflow`=0.
- ALU hookup: x1=0x7FFFFFFF, x2=0x00000001, ALU add with `flag_capture` -> ALU overflow=1 captured, `sticky_overflow`=1 next cycle. Write-back of 0x80000000 to x3 reads back 0x80000000.
